pipe_field: RTL



---
 rtl/pipe_field.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_field.sv
// Scrolling pipe field for the flappy-bird LED game: pipe generation, collision and score.
// Optional PIPE_FIELD_SPEEDUP_EN shortens the step period as the score grows.
//
// state | meaning
// IDLE  | waiting for the first start, field blank
// PLAY  | pipes scroll on every divider step, bird checked every clock
// OVER  | collision or floor hit seen, field and score frozen until start
module pipe_field #(
  parameter int          TICK_MAX  = 191,
  parameter int          GAP_H     = 3,
  parameter int          SPACING   = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      bird_row,
  input  logic            bird_lose,
  output logic [7:0][7:0] pipes,
  output logic            collide,
  output logic [7:0]      score,
  output logic            playing
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  localparam int              CW         = $clog2(TICK_MAX + 2);
  localparam int              SW         = (SPACING < 2) ? 1 : $clog2(SPACING);
  localparam logic [CW-1:0]   TICK_LAST  = CW'(TICK_MAX);
  localparam logic [SW-1:0]   SPAWN_LAST = SW'(SPACING - 1);
  localparam logic [7:0]      GAP_ONES   = 8'((1 << GAP_H) - 1);
  localparam logic [7:0]      LFSR_MASK  = 8'hB8;

  logic [1:0]      state_q, state_d;
  logic [7:0][7:0] pipes_q, pipes_d;
  logic [7:0]      score_q, score_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   spawn_q, spawn_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            collide_q, collide_d;
  logic            playing_q, playing_d;

  logic            hit;
  logic            step;
  logic [2:0]      base;
  logic [7:0]      spawn_col;
  logic [7:0]      lfsr_next;
  logic [CW-1:0]   tick_limit;

`ifdef PIPE_FIELD_SPEEDUP_EN
  localparam int FLOOR_I = TICK_MAX / 3;
  logic [CW-1:0] limit_q, limit_d;
  assign tick_limit = limit_q;
`else
  assign tick_limit = TICK_LAST;
`endif

  assign hit       = (|(pipes_q[0] & bird_row)) | bird_lose;
  assign step      = (cnt_q == tick_limit);
  assign base      = 3'(32'(lfsr_q[2:0]) % (9 - GAP_H));
  assign spawn_col = ~(GAP_ONES << base);
  assign lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_MASK : 8'h00);

  always_comb begin
    state_d = state_q;
    pipes_d = pipes_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    spawn_d = spawn_q;
    lfsr_d  = lfsr_q;
`ifdef PIPE_FIELD_SPEEDUP_EN
    limit_d = limit_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          pipes_d = '0;
          score_d = 8'h00;
          cnt_d   = '0;
          spawn_d = '0;
`ifdef PIPE_FIELD_SPEEDUP_EN
          limit_d = TICK_LAST;
`endif
        end
      end
      PLAY: begin
        // A collision wins over a coincident step: freeze without shifting or scoring.
        if (hit) begin
          state_d = OVER;
        end else if (step) begin
          cnt_d = '0;
          for (int c = 0; c < 7; c++) pipes_d[c] = pipes_q[c+1];
          pipes_d[7] = (spawn_q == '0) ? spawn_col : 8'h00;
          if (spawn_q == '0) lfsr_d = lfsr_next;
          spawn_d = (spawn_q == SPAWN_LAST) ? '0 : spawn_q + 1'b1;
          if (pipes_q[0] != 8'h00 && score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
`ifdef PIPE_FIELD_SPEEDUP_EN
            if (score_d[2:0] == 3'd0) begin
              if (int'(limit_q) < FLOOR_I + 16) limit_d = CW'(FLOOR_I);
              else                              limit_d = limit_q - CW'(16);
            end
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    collide_d = (state_d == OVER);
    playing_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pipes_q   <= '0;
      score_q   <= 8'h00;
      cnt_q     <= '0;
      spawn_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      collide_q <= 1'b0;
      playing_q <= 1'b0;
`ifdef PIPE_FIELD_SPEEDUP_EN
      limit_q   <= TICK_LAST;
`endif
    end else begin
      state_q   <= state_d;
      pipes_q   <= pipes_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      spawn_q   <= spawn_d;
      lfsr_q    <= lfsr_d;
      collide_q <= collide_d;
      playing_q <= playing_d;
`ifdef PIPE_FIELD_SPEEDUP_EN
      limit_q   <= limit_d;
`endif
    end
  end

  assign pipes   = pipes_q;
  assign score   = score_q;
  assign collide = collide_q;
  assign playing = playing_q;

endmodule
